memory_access: RTL and testbench

Memory stage of the in-order RISC-V pipeline: consumes the `ex_mem` bundle produced by execute, performs loads and stores over the data bus (`dreq`/`dresp` valid/ok handshake), and emits a registered `mem_wb` bundle to writeback. Non-memory instructions pass through with one cycle of latency. Memory instructions hold the stage busy (`in_ready` low) until the bus returns `data_ok`.

---
 rtl/memory_access_pkg.sv | 65 ++++++
 rtl/memory_access_if.sv | 38 +++
 rtl/memory_access_load_extend.sv | 32 +++
 rtl/memory_access.sv | 109 ++++++++++
 tb/tb_memory_access.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_access_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : memory_access_pkg                                          |
// | Description : Shared widths, size encodings, strobe lookup and the       |
// |               ex_mem / mem_wb bundles for the memory stage.              |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
package memory_access_pkg;

  localparam int XLEN  = 64;
  localparam int REG_W = 5;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [1:0] SIZE_D = 2'd3;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
  } inst_signal_t;

  typedef struct packed {
    logic [XLEN-1:0]  alu_result;
    logic [XLEN-1:0]  store_data;
    logic [REG_W-1:0] reg_dest_addr;
    logic             reg_write_enable;
    inst_signal_t     inst_signal;
    logic [31:0]      inst;
    logic [XLEN-1:0]  inst_pc;
  } ex_mem_t;

  typedef struct packed {
    logic [REG_W-1:0] reg_dest_addr;
    logic             reg_write_enable;
    logic [XLEN-1:0]  wb_value;
    inst_signal_t     inst_signal;
    logic [31:0]      inst;
    logic [XLEN-1:0]  inst_pc;
  } mem_wb_t;

  function automatic logic [7:0] strobe_mask(input logic [1:0] size);
    case (size)
      SIZE_B:  strobe_mask = 8'h01;
      SIZE_H:  strobe_mask = 8'h03;
      SIZE_W:  strobe_mask = 8'h0F;
      default: strobe_mask = 8'hFF;
    endcase
  endfunction

  function automatic mem_wb_t make_mem_wb(input ex_mem_t em, input logic [XLEN-1:0] value);
    mem_wb_t r;
    r.reg_dest_addr    = em.reg_dest_addr;
    r.reg_write_enable = em.reg_write_enable;
    r.wb_value         = value;
    r.inst_signal      = em.inst_signal;
    r.inst             = em.inst;
    r.inst_pc          = em.inst_pc;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_access_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : memory_access_if                                           |
// | Description : Pipeline-side and data-bus handshake signals of the memory |
// |               stage. master = the stage, slave = its environment.        |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
interface memory_access_if;
  import memory_access_pkg::*;

  logic            in_valid;
  ex_mem_t         ex_mem_state;
  logic            in_ready;
  logic            dreq_valid;
  logic [XLEN-1:0] dreq_addr;
  logic [1:0]      dreq_size;
  logic [7:0]      dreq_strobe;
  logic [XLEN-1:0] dreq_data;
  logic            dresp_addr_ok;
  logic            dresp_data_ok;
  logic [XLEN-1:0] dresp_data;
  logic            out_valid;
  mem_wb_t         mem_wb_state;

  modport master (
    input  in_valid, ex_mem_state, dresp_addr_ok, dresp_data_ok, dresp_data,
    output in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
           out_valid, mem_wb_state
  );

  modport slave (
    output in_valid, ex_mem_state, dresp_addr_ok, dresp_data_ok, dresp_data,
    input  in_ready, dreq_valid, dreq_addr, dreq_size, dreq_strobe, dreq_data,
           out_valid, mem_wb_state
  );

endinterface
`default_nettype wire

// File: rtl/memory_access_load_extend.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : load_extend                                                |
// | Description : Selects the addressed lane of a raw 64-bit load word and   |
// |               zero/sign-extends it to 64 bits.                           |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module load_extend
  import memory_access_pkg::*;
(
  input  logic [XLEN-1:0] raw,
  input  logic [2:0]      offset,
  input  logic [1:0]      size,
  input  logic            is_unsigned,
  output logic [XLEN-1:0] value
);

  logic [XLEN-1:0] shifted;
  assign shifted = raw >> {offset, 3'b000};

  always_comb begin
    value = shifted;
    case (size)
      SIZE_B:  value = is_unsigned ? {56'b0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      SIZE_H:  value = is_unsigned ? {48'b0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      SIZE_W:  value = is_unsigned ? {32'b0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      default: value = shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/memory_access.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : memory_access                                              |
// | Description : Memory stage: ALU results pass through in one cycle, loads |
// |               and stores hold the stage until the bus reports data_ok.   |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module memory_access
  import memory_access_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  memory_access_if.master mem_if
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  ex_mem_t         req_q, req_d;
  logic            out_valid_q, out_valid_d;
  mem_wb_t         mem_wb_q, mem_wb_d;
  logic            finish;
  logic [2:0]      lane_off;
  logic [XLEN-1:0] load_value;
  logic            busy;

  assign lane_off = req_q.alu_result[2:0];
  assign busy     = (state_q != ST_IDLE);

  load_extend u_load_extend (
    .raw         (mem_if.dresp_data),
    .offset      (lane_off),
    .size        (req_q.inst_signal.mem_size),
    .is_unsigned (req_q.inst_signal.mem_unsigned),
    .value       (load_value)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    out_valid_d = 1'b0;
    mem_wb_d    = mem_wb_q;
    finish      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_if.in_valid) begin
          req_d = mem_if.ex_mem_state;
          if (mem_if.ex_mem_state.inst_signal.mem_read || mem_if.ex_mem_state.inst_signal.mem_write) begin
            state_d = ST_REQ;
          end else begin
            out_valid_d = 1'b1;
            mem_wb_d    = make_mem_wb(mem_if.ex_mem_state, mem_if.ex_mem_state.alu_result);
          end
        end
      end
      ST_REQ: begin
        if (mem_if.dresp_addr_ok && mem_if.dresp_data_ok) begin
          finish = 1'b1;
        end else if (mem_if.dresp_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_if.dresp_data_ok) begin
          finish = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load data is only meaningful in the data_ok cycle, so it is captured here.
    if (finish) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b1;
      mem_wb_d    = make_mem_wb(req_q, req_q.inst_signal.mem_read ? load_value : req_q.alu_result);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      out_valid_q <= 1'b0;
      mem_wb_q    <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      out_valid_q <= out_valid_d;
      mem_wb_q    <= mem_wb_d;
    end
  end

  // Bus outputs come from state and the captured bundle only.
  assign mem_if.in_ready     = ~busy;
  assign mem_if.dreq_valid   = busy;
  assign mem_if.dreq_addr    = req_q.alu_result;
  assign mem_if.dreq_size    = req_q.inst_signal.mem_size;
  assign mem_if.dreq_strobe  = (busy && req_q.inst_signal.mem_write)
                               ? (strobe_mask(req_q.inst_signal.mem_size) << lane_off) : 8'h00;
  assign mem_if.dreq_data    = req_q.store_data << {lane_off, 3'b000};
  assign mem_if.out_valid    = out_valid_q;
  assign mem_if.mem_wb_state = mem_wb_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_access.sv
`default_nettype none
// ----------------------------------------------------------------------------
// | Module      : tb_memory_access                                           |
// | Description : Directed self-checking bench for the memory stage.         |
// | Revision    : 1.0 - initial release                                      |
// ----------------------------------------------------------------------------
module tb_memory_access;
  import memory_access_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  memory_access_if bus ();

  memory_access u_dut (
    .clk    (clk),
    .reset  (reset),
    .mem_if (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic ex_mem_t em(input logic [63:0] alu, input logic [63:0] sdata,
                                 input logic [4:0] rd, input logic we, input logic rd_en,
                                 input logic wr_en, input logic [1:0] size, input logic uns);
    ex_mem_t e;
    e = '0;
    e.alu_result                = alu;
    e.store_data                = sdata;
    e.reg_dest_addr             = rd;
    e.reg_write_enable          = we;
    e.inst_signal.mem_read      = rd_en;
    e.inst_signal.mem_write     = wr_en;
    e.inst_signal.mem_size      = size;
    e.inst_signal.mem_unsigned  = uns;
    e.inst                      = 32'h0000_0013;
    e.inst_pc                   = 64'h8000_1000;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset                 = 1'b1;
    bus.in_valid          = 1'b0;
    bus.ex_mem_state      = '0;
    bus.dresp_addr_ok     = 1'b0;
    bus.dresp_data_ok     = 1'b0;
    bus.dresp_data        = '0;
    step();
    step();
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_checks++;
    if (bus.dreq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dreq_valid: got %b want 0", bus.dreq_valid); end
    n_checks++;
    if (bus.dreq_strobe !== 8'h00) begin n_fail++; $display("FAIL reset_strobe: got %h want 00", bus.dreq_strobe); end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_checks++;
    if (bus.mem_wb_state !== mem_wb_t'('0)) begin n_fail++; $display("FAIL reset_mem_wb: got %h want 0", bus.mem_wb_state); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_alu_pass();
    bus.ex_mem_state = em(64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, SIZE_D, 1'b0);
    bus.in_valid     = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL alu_out_valid: got %b want 1", bus.out_valid); end
    n_checks++;
    if (bus.mem_wb_state.wb_value !== 64'h1234) begin n_fail++; $display("FAIL alu_wb_value: got %h want 1234", bus.mem_wb_state.wb_value); end
    n_checks++;
    if (bus.mem_wb_state.reg_dest_addr !== 5'd5 || bus.mem_wb_state.reg_write_enable !== 1'b1) begin
      n_fail++; $display("FAIL alu_rd: got rd=%0d we=%b want rd=5 we=1", bus.mem_wb_state.reg_dest_addr, bus.mem_wb_state.reg_write_enable);
    end
    n_checks++;
    if (bus.dreq_valid !== 1'b0) begin n_fail++; $display("FAIL alu_dreq_valid: got %b want 0", bus.dreq_valid); end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL alu_out_pulse: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_store_byte();
    bus.ex_mem_state = em(64'h8000_0003, 64'hAB, 5'd0, 1'b0, 1'b0, 1'b1, SIZE_B, 1'b0);
    bus.in_valid     = 1'b1;
    step();
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.dreq_valid !== 1'b1 || bus.dreq_strobe !== 8'h08 || bus.dreq_size !== 2'd0) begin
      n_fail++; $display("FAIL sb_req: got valid=%b strobe=%h size=%0d want 1/08/0", bus.dreq_valid, bus.dreq_strobe, bus.dreq_size);
    end
    n_checks++;
    if (bus.dreq_data[31:24] !== 8'hAB || bus.dreq_addr !== 64'h8000_0003) begin
      n_fail++; $display("FAIL sb_data: got data=%h addr=%h want lane3=AB addr=80000003", bus.dreq_data, bus.dreq_addr);
    end
    for (int c = 1; c <= 4; c++) begin
      n_checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.dreq_valid !== 1'b1) begin
        n_fail++; $display("FAIL sb_busy_c%0d: got ready=%b out=%b dreq=%b want 0/0/1", c, bus.in_ready, bus.out_valid, bus.dreq_valid);
      end
      bus.dresp_addr_ok = (c == 2);
      bus.dresp_data_ok = (c == 4);
      step();
    end
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_wb_state.wb_value !== 64'h8000_0003) begin
      n_fail++; $display("FAIL sb_finish: got out=%b wb=%h want 1/80000003", bus.out_valid, bus.mem_wb_state.wb_value);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.dreq_valid !== 1'b0) begin
      n_fail++; $display("FAIL sb_idle: got ready=%b dreq=%b want 1/0", bus.in_ready, bus.dreq_valid);
    end
    step();
  endtask

  task automatic test_load_half();
    logic [63:0] want [2];
    want[0] = 64'hFFFF_FFFF_FFFF_8001;
    want[1] = 64'h0000_0000_0000_8001;
    for (int u = 0; u < 2; u++) begin
      bus.ex_mem_state = em(64'h0000_0000_0000_1006, 64'h0, 5'd7, 1'b1, 1'b1, 1'b0, SIZE_H, u[0]);
      bus.in_valid     = 1'b1;
      step();
      bus.in_valid = 1'b0;
      n_checks++;
      if (bus.dreq_strobe !== 8'h00 || bus.dreq_size !== 2'd1) begin
        n_fail++; $display("FAIL lh_req_u%0d: got strobe=%h size=%0d want 00/1", u, bus.dreq_strobe, bus.dreq_size);
      end
      bus.dresp_addr_ok = 1'b1;
      bus.dresp_data_ok = 1'b1;
      bus.dresp_data    = 64'h8001_0000_0000_0000;
      step();
      bus.dresp_addr_ok = 1'b0;
      bus.dresp_data_ok = 1'b0;
      bus.dresp_data    = 64'h0;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.mem_wb_state.wb_value !== want[u]) begin
        n_fail++; $display("FAIL lh_value_u%0d: got out=%b wb=%h want 1/%h", u, bus.out_valid, bus.mem_wb_state.wb_value, want[u]);
      end
      step();
    end
  endtask

  task automatic test_load_double_stall();
    bus.dresp_data_ok = 1'b1;
    step();
    bus.dresp_data_ok = 1'b0;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stray_data_ok: got out=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    bus.ex_mem_state = em(64'h2000_0008, 64'h0, 5'd9, 1'b1, 1'b1, 1'b0, SIZE_D, 1'b0);
    bus.in_valid     = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (bus.dreq_valid !== 1'b1 || bus.dreq_addr !== 64'h2000_0008 || bus.dreq_size !== 2'd3) begin
        n_fail++; $display("FAIL ld_stable_c%0d: got v=%b addr=%h size=%0d want 1/20000008/3", c, bus.dreq_valid, bus.dreq_addr, bus.dreq_size);
      end
      if (c < 3) step();
    end
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 64'hFEDC_BA98_7654_3210;
    step();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_wb_state.wb_value !== 64'hFEDC_BA98_7654_3210) begin
      n_fail++; $display("FAIL ld_value: got out=%b wb=%h want 1/fedcba9876543210", bus.out_valid, bus.mem_wb_state.wb_value);
    end
    step();
  endtask

  task automatic test_reset_in_wait();
    bus.ex_mem_state = em(64'h3000_0000, 64'h0, 5'd3, 1'b1, 1'b1, 1'b0, SIZE_W, 1'b0);
    bus.in_valid     = 1'b1;
    step();
    bus.in_valid      = 1'b0;
    bus.dresp_addr_ok = 1'b1;
    step();
    bus.dresp_addr_ok = 1'b0;
    reset             = 1'b1;
    #1;
    n_checks++;
    if (bus.dreq_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_wait_async: got dreq=%b ready=%b want 0/1", bus.dreq_valid, bus.in_ready);
    end
    step();
    reset             = 1'b0;
    bus.dresp_data_ok = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_out_c%0d: got %b want 0", c, bus.out_valid); end
    end
    bus.dresp_data_ok = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    bus.ex_mem_state = em(64'h11, 64'h0, 5'd1, 1'b1, 1'b0, 1'b0, SIZE_D, 1'b0);
    bus.in_valid     = 1'b1;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_wb_state.wb_value !== 64'h11) begin
      n_fail++; $display("FAIL b2b_alu1: got out=%b wb=%h want 1/11", bus.out_valid, bus.mem_wb_state.wb_value);
    end
    bus.ex_mem_state = em(64'h4004, 64'h0, 5'd2, 1'b1, 1'b1, 1'b0, SIZE_W, 1'b0);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL b2b_lw_req: got out=%b ready=%b want 0/0", bus.out_valid, bus.in_ready);
    end
    bus.ex_mem_state  = em(64'h22, 64'h0, 5'd4, 1'b1, 1'b0, 1'b0, SIZE_D, 1'b0);
    bus.dresp_addr_ok = 1'b1;
    bus.dresp_data_ok = 1'b1;
    bus.dresp_data    = 64'h8765_4321_0000_0000;
    step();
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_wb_state.wb_value !== 64'hFFFF_FFFF_8765_4321 || bus.mem_wb_state.reg_dest_addr !== 5'd2) begin
      n_fail++; $display("FAIL b2b_lw: got out=%b wb=%h rd=%0d want 1/ffffffff87654321/2", bus.out_valid, bus.mem_wb_state.wb_value, bus.mem_wb_state.reg_dest_addr);
    end
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_wb_state.wb_value !== 64'h22 || bus.mem_wb_state.reg_dest_addr !== 5'd4) begin
      n_fail++; $display("FAIL b2b_alu2: got out=%b wb=%h rd=%0d want 1/22/4", bus.out_valid, bus.mem_wb_state.wb_value, bus.mem_wb_state.reg_dest_addr);
    end
    bus.ex_mem_state = em(64'h33, 64'h0, 5'd6, 1'b1, 1'b0, 1'b0, SIZE_D, 1'b0);
    step();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.mem_wb_state.wb_value !== 64'h33) begin
      n_fail++; $display("FAIL b2b_alu3: got out=%b wb=%h want 1/33", bus.out_valid, bus.mem_wb_state.wb_value);
    end
    bus.in_valid = 1'b0;
    step();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", bus.out_valid); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_alu_pass();
    test_store_byte();
    test_load_half();
    test_load_double_stall();
    test_reset_in_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
